ase_hssi_stream_capture: RTL and testbench
==========================================

Name: ase_hssi_stream_capture

Overview:
- Passive multi-channel HSSI AXI-Stream beat monitor.
- Snoops NUM_CH channels and timestamps every accepted beat (tvalid & tready).
- Arbitrates captured beats round-robin into one shared record FIFO and presents records on a valid/ready stream to the simulation-side log drainer.
- Sits beside the HSSI channel models; never back-pressures the monitored links. Overflow is counted per channel, never stalled.

Parameters:
- NUM_CH, 4, number of monitored channels (1..16)
- DATA_W, 64, tdata width per channel
- FIFO_DEPTH, 16, record FIFO entries (power of 2, >=2)
- TS_W, 32, timestamp counter width
- DROP_W, 16, per-channel drop counter width

Ports:
- clk  in  1  clock
- SoftReset_n  in  1  asynchronous active-low reset
- enable  in  1  capture enable; draining continues when low
- ch_tvalid  in  NUM_CH  monitored tvalid
- ch_tready  in  NUM_CH  monitored tready
- ch_tlast  in  NUM_CH  monitored tlast
- ch_tdata  in  NUM_CH*DATA_W  monitored tdata, channel i at [i*DATA_W +: DATA_W]
- rec_valid  out  1  record available
- rec_ready  in  1  drainer accepts record
- rec_ts  out  TS_W  capture timestamp
- rec_ch  out  $clog2(NUM_CH) or 1 if NUM_CH==1  source channel
- rec_last  out  1  captured tlast
- rec_data  out  DATA_W  captured tdata
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy
- drop_cnt  out  NUM_CH*DROP_W  per-channel dropped-beat counters, saturating
- overflow  out  1  sticky: any drop since reset

Behaviour:
- Reset (async assert, sync release): ts=0, all hold regs empty, FIFO empty, rec_valid=0, fifo_count=0, drop_cnt=0, overflow=0, rr pointer=NUM_CH-1 (ch0 has first priority). rec_* data outputs=0.
- Timestamp: free-running, increments every clk, wraps 2^TS_W-1 -> 0.
- Capture: at edge t, if enable & ch_tvalid[i] & ch_tready[i], hold_i loads {ts, last, data}. ts is the value before the increment at that edge.
- Hold register per channel, 1 deep. States: EMPTY, FULL.
  - EMPTY -> FULL on capture.
  - FULL -> EMPTY on grant with no capture.
  - FULL stays FULL on grant with simultaneous capture: reload, no drop.
  - FULL with capture and no grant: new beat dropped, drop_cnt[i]++ (saturates at all-ones), overflow=1. Old beat retained.
- Arbiter: grant at most one channel per cycle when any hold is FULL and push is allowed.
  - Push is allowed when fifo_count < FIFO_DEPTH, or when the FIFO is full and a pop happens the same cycle.
  - Search starts at rr+1 mod NUM_CH; rr updates to the granted channel.
- FIFO: show-ahead. rec_valid = count!=0; rec_* reflect the head entry. Pop on rec_valid & rec_ready.
  - Simultaneous push+pop: count unchanged.
  - Pop on empty: ignored. rec_ready is don't-care while rec_valid=0.
- Latency: beat captured at edge t, channel granted at edge t+1 (no contention, FIFO not full), rec_valid=1 after edge t+1, i.e. during cycle t+2. Minimum 2 cycles.
- enable deasserted mid-stream: no new captures. Holds and FIFO drain normally. Drop counting only applies to enabled captures.
- Monitored signals are only sampled; no output drives the links.
- Reset asserted mid-operation: all contents discarded immediately; counters and sticky flag cleared.

Decomposition:
- Package ase_hssi_capture_pkg:
  - function clog2_min1(n)
  - localparam MAX_CH=16
  - typedef enum {HOLD_EMPTY, HOLD_FULL}
- Record is a packed struct declared inside the module, since the width is parameter-dependent.
- Sub-module ase_hssi_capture_fifo: parametrised WIDTH/DEPTH sync show-ahead FIFO with count. Same clk/SoftReset_n.
- Arbiter and hold registers stay in the top module.

Test Plan:
- Single beat: ch2 accepted at ts=5, data=0xA5, last=1, rec_ready=1 -> rec_valid in cycle t+2 with rec_ch=2, rec_ts=5, rec_data=0xA5, rec_last=1; fifo_count returns to 0.
- Contention: ch0..3 all accepted at the same edge, continuous rec_ready -> records emerge in order ch0,1,2,3 with identical rec_ts; next burst also starts ch0 (rr rotated past 3).
- Back-pressure: rec_ready=0, ch0 streams every cycle for 20 cycles, FIFO_DEPTH=16 -> 16 records plus 1 held, drop_cnt[0]=3, overflow=1; raise rec_ready -> exactly 17 records, in order, with consecutive ts.
- Grant+capture same cycle: ch1 streams every cycle with the FIFO not full -> zero drops, every beat logged with ts stepping by 1.
- enable=0 with 3 beats held or queued -> no new records from further beats; existing 3 drain; drop_cnt unchanged.
- Timestamp wrap with TS_W=4: beats at ts=15 and ts=0 -> rec_ts 15 then 0. Reset pulse mid-FIFO (count=5) -> rec_valid=0, count=0, drop_cnt=0, overflow=0 immediately.

Source files
------------

// File: rtl/ase_hssi_capture_pkg.sv
// Shared definitions for the HSSI stream capture monitor.
//   clog2_min1  : index width helper that never returns 0 (single-channel case)
//   MAX_CH      : upper bound on monitored channels
//   hold_state_e: per-channel one-deep hold register occupancy
package ase_hssi_capture_pkg;

  localparam int unsigned MAX_CH = 16;

  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_e;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ase_hssi_capture_fifo.sv
// Synchronous show-ahead FIFO with occupancy count.
//   clk, SoftReset_n : clock, asynchronous active-low reset
//   push, push_data  : write request and data (write while full only with a pop)
//   pop              : read request, ignored when empty
//   head_data        : oldest entry, zero while empty
//   count            : occupancy 0..DEPTH
module ase_hssi_capture_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       SoftReset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Storage is not reset; gating keeps the head at zero while empty.
  assign head_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/ase_hssi_stream_capture.sv
// Passive multi-channel AXI-Stream beat monitor. Every accepted beat
// (tvalid & tready) is timestamped into a one-deep per-channel hold register,
// arbitrated round-robin into a shared record FIFO and presented on a
// valid/ready record stream. The monitored links are never back-pressured;
// beats that find their hold register occupied are dropped and counted.
//   clk, SoftReset_n         : clock, asynchronous active-low reset
//   enable                   : capture enable (draining continues when low)
//   ch_tvalid/tready/tlast   : monitored handshake per channel
//   ch_tdata                 : monitored data, channel i at [i*DATA_W +: DATA_W]
//   rec_valid/rec_ready      : record stream handshake
//   rec_ts/ch/last/data      : head record fields
//   fifo_count               : record FIFO occupancy
//   drop_cnt                 : saturating per-channel drop counters
//   overflow                 : sticky, any drop since reset
module ase_hssi_stream_capture
  import ase_hssi_capture_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned TS_W       = 32,
  parameter int unsigned DROP_W     = 16
) (
  input  logic                             clk,
  input  logic                             SoftReset_n,
  input  logic                             enable,
  input  logic [NUM_CH-1:0]                ch_tvalid,
  input  logic [NUM_CH-1:0]                ch_tready,
  input  logic [NUM_CH-1:0]                ch_tlast,
  input  logic [NUM_CH*DATA_W-1:0]         ch_tdata,
  output logic                             rec_valid,
  input  logic                             rec_ready,
  output logic [TS_W-1:0]                  rec_ts,
  output logic [clog2_min1(NUM_CH)-1:0]    rec_ch,
  output logic                             rec_last,
  output logic [DATA_W-1:0]                rec_data,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_count,
  output logic [NUM_CH*DROP_W-1:0]         drop_cnt,
  output logic                             overflow
);

  localparam int unsigned CH_W  = clog2_min1(NUM_CH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [TS_W-1:0]   ts;
    logic [CH_W-1:0]   ch;
    logic              last;
    logic [DATA_W-1:0] data;
  } rec_t;

  localparam int unsigned REC_W = $bits(rec_t);

  logic [TS_W-1:0]   ts;
  logic [CH_W-1:0]   rr;
  hold_state_e       hold_st   [NUM_CH];
  logic [TS_W-1:0]   hold_ts   [NUM_CH];
  logic              hold_last [NUM_CH];
  logic [DATA_W-1:0] hold_data [NUM_CH];
  logic [DROP_W-1:0] drop_q    [NUM_CH];

  logic [NUM_CH-1:0] capture;
  logic [NUM_CH-1:0] granted;
  logic              grant_valid;
  logic [CH_W-1:0]   grant_ch;
  logic              pop;
  logic              push_ok;
  rec_t              push_rec;
  rec_t              head_rec;
  logic [REC_W-1:0]  head_data;

  assign capture   = {NUM_CH{enable}} & ch_tvalid & ch_tready;
  assign rec_valid = (fifo_count != '0);
  assign pop       = rec_valid && rec_ready;
  assign push_ok   = (fifo_count != CNT_W'(FIFO_DEPTH)) || pop;

  // Round-robin: first FULL hold starting one past the last grant.
  always_comb begin
    grant_valid = 1'b0;
    grant_ch    = '0;
    for (int unsigned off = 1; off <= NUM_CH; off++) begin
      if (!grant_valid &&
          hold_st[(32'(rr) + off) % NUM_CH] == HOLD_FULL) begin
        grant_valid = 1'b1;
        grant_ch    = CH_W'((32'(rr) + off) % NUM_CH);
      end
    end
    if (!push_ok) grant_valid = 1'b0;
    granted = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      granted[i] = grant_valid && (grant_ch == CH_W'(i));
    end
  end

  always_comb begin
    push_rec      = '0;
    push_rec.ts   = hold_ts[grant_ch];
    push_rec.ch   = grant_ch;
    push_rec.last = hold_last[grant_ch];
    push_rec.data = hold_data[grant_ch];
  end

  always_ff @(posedge clk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      ts       <= '0;
      rr       <= CH_W'(NUM_CH - 1);
      overflow <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        hold_st[i]   <= HOLD_EMPTY;
        hold_ts[i]   <= '0;
        hold_last[i] <= 1'b0;
        hold_data[i] <= '0;
        drop_q[i]    <= '0;
      end
    end else begin
      ts <= ts + 1'b1;
      if (grant_valid) rr <= grant_ch;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (capture[i]) begin
          // A grant in the same cycle frees the slot, so the new beat reloads.
          if (hold_st[i] == HOLD_EMPTY || granted[i]) begin
            hold_st[i]   <= HOLD_FULL;
            hold_ts[i]   <= ts;
            hold_last[i] <= ch_tlast[i];
            hold_data[i] <= ch_tdata[i*DATA_W +: DATA_W];
          end else begin
            if (drop_q[i] != '1) drop_q[i] <= drop_q[i] + 1'b1;
            overflow <= 1'b1;
          end
        end else if (granted[i]) begin
          hold_st[i] <= HOLD_EMPTY;
        end
      end
    end
  end

  ase_hssi_capture_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .SoftReset_n (SoftReset_n),
    .push        (grant_valid),
    .push_data   (push_rec),
    .pop         (pop),
    .head_data   (head_data),
    .count       (fifo_count)
  );

  assign head_rec = head_data;
  assign rec_ts   = head_rec.ts;
  assign rec_ch   = head_rec.ch;
  assign rec_last = head_rec.last;
  assign rec_data = head_rec.data;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_drop
    assign drop_cnt[g*DROP_W +: DROP_W] = drop_q[g];
  end

endmodule

// File: tb/tb_ase_hssi_stream_capture.sv
module tb_ase_hssi_stream_capture;

  localparam int NCH = 4;
  localparam int DW  = 64;
  localparam int FD  = 16;
  localparam int TW  = 4;
  localparam int DRW = 16;

  logic            clk = 1'b0;
  logic            SoftReset_n = 1'b0;
  logic            enable = 1'b1;
  logic [NCH-1:0]  ch_tvalid = '0;
  logic [NCH-1:0]  ch_tready = '0;
  logic [NCH-1:0]  ch_tlast = '0;
  logic [NCH*DW-1:0] ch_tdata = '0;
  logic            rec_valid;
  logic            rec_ready = 1'b0;
  logic [TW-1:0]   rec_ts;
  logic [1:0]      rec_ch;
  logic            rec_last;
  logic [DW-1:0]   rec_data;
  logic [4:0]      fifo_count;
  logic [NCH*DRW-1:0] drop_cnt;
  logic            overflow;

  ase_hssi_stream_capture #(
    .NUM_CH     (NCH),
    .DATA_W     (DW),
    .FIFO_DEPTH (FD),
    .TS_W       (TW),
    .DROP_W     (DRW)
  ) dut (
    .clk         (clk),
    .SoftReset_n (SoftReset_n),
    .enable      (enable),
    .ch_tvalid   (ch_tvalid),
    .ch_tready   (ch_tready),
    .ch_tlast    (ch_tlast),
    .ch_tdata    (ch_tdata),
    .rec_valid   (rec_valid),
    .rec_ready   (rec_ready),
    .rec_ts      (rec_ts),
    .rec_ch      (rec_ch),
    .rec_last    (rec_last),
    .rec_data    (rec_data),
    .fifo_count  (fifo_count),
    .drop_cnt    (drop_cnt),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: per-channel pending beat, a queue of records,
  // a round-robin pointer and the current timestamp.
  typedef struct {
    logic [TW-1:0] ts;
    int            ch;
    logic          last;
    logic [DW-1:0] data;
  } mrec_t;

  mrec_t          mq[$];
  mrec_t          mheld[NCH];
  bit             mfull[NCH];
  logic [DRW-1:0] mdrop[NCH];
  bit             movf = 1'b0;
  int             mrr = NCH - 1;
  logic [TW-1:0]  m_ts = '0;
  bit             mpop, mpok, mcap;
  int             mg, mc;

  always @(posedge clk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      mq.delete();
      for (int i = 0; i < NCH; i++) begin
        mfull[i] = 1'b0;
        mdrop[i] = '0;
      end
      movf = 1'b0;
      mrr  = NCH - 1;
      m_ts = '0;
    end else begin
      mpop = (mq.size() != 0) && rec_ready;
      mpok = (mq.size() < FD) || mpop;
      mg   = -1;
      if (mpok) begin
        for (int k = 1; k <= NCH; k++) begin
          mc = (mrr + k) % NCH;
          if (mg < 0 && mfull[mc]) mg = mc;
        end
      end
      if (mpop) void'(mq.pop_front());
      if (mg >= 0) begin
        mq.push_back(mheld[mg]);
        mrr = mg;
      end
      for (int i = 0; i < NCH; i++) begin
        mcap = enable && ch_tvalid[i] && ch_tready[i];
        if (mcap) begin
          if (!mfull[i] || mg == i) begin
            mheld[i].ts   = m_ts;
            mheld[i].ch   = i;
            mheld[i].last = ch_tlast[i];
            mheld[i].data = ch_tdata[i*DW +: DW];
            mfull[i] = 1'b1;
          end else begin
            if (mdrop[i] != 16'hFFFF) mdrop[i] = mdrop[i] + 1'b1;
            movf = 1'b1;
          end
        end else if (mg == i) begin
          mfull[i] = 1'b0;
        end
      end
      m_ts = m_ts + 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("rec_valid", rec_valid, mq.size() != 0);
    chk("fifo_count", fifo_count, mq.size());
    chk("overflow", overflow, movf);
    for (int i = 0; i < NCH; i++) chk("drop_cnt", drop_cnt[i*DRW +: DRW], mdrop[i]);
    if (mq.size() != 0) begin
      chk("rec_ts", rec_ts, mq[0].ts);
      chk("rec_ch", rec_ch, mq[0].ch);
      chk("rec_last", rec_last, mq[0].last);
      chk("rec_data", rec_data, mq[0].data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_links();
    ch_tvalid = '0;
    ch_tready = '0;
    ch_tlast  = '0;
  endtask

  task automatic burst_all(input string nm);
    logic [TW-1:0] tsv;
    rec_ready = 1'b1;
    ch_tvalid = '1;
    ch_tready = '1;
    ch_tlast  = 4'b1010;
    for (int i = 0; i < NCH; i++) ch_tdata[i*DW +: DW] = 64'h1000 + 64'(i);
    tsv = m_ts;
    step();
    clear_links();
    chk({nm, "_lat"}, rec_valid, 1'b0);
    step();
    for (int k = 0; k < NCH; k++) begin
      chk({nm, "_ch"}, rec_ch, k);
      chk({nm, "_ts"}, rec_ts, tsv);
      chk({nm, "_data"}, rec_data, 64'h1000 + 64'(k));
      step();
    end
    chk({nm, "_empty"}, fifo_count, 0);
  endtask

  logic [TW-1:0] start_ts;
  logic [TW-1:0] exp_ts;
  int            n;

  initial begin
    ch_tdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", rec_valid, 1'b0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_data", rec_data, 0);
    SoftReset_n = 1'b1;
    step();

    // Contention: rr starts at NUM_CH-1, so both bursts begin at ch0.
    burst_all("burst1");
    step();
    burst_all("burst2");

    // Single beat on ch2 at ts=5.
    rec_ready = 1'b1;
    while (m_ts != 4'd5) step();
    ch_tvalid[2] = 1'b1;
    ch_tready[2] = 1'b1;
    ch_tlast[2]  = 1'b1;
    ch_tdata[2*DW +: DW] = 64'hA5;
    step();
    clear_links();
    chk("single_lat", rec_valid, 1'b0);
    step();
    chk("single_valid", rec_valid, 1'b1);
    chk("single_ch", rec_ch, 2);
    chk("single_ts", rec_ts, 5);
    chk("single_data", rec_data, 64'hA5);
    chk("single_last", rec_last, 1'b1);
    chk("single_cnt1", fifo_count, 1);
    step();
    chk("single_cnt0", fifo_count, 0);

    // Back-pressure: 20 beats on ch0 into 16 entries + 1 hold.
    rec_ready = 1'b0;
    ch_tvalid[0] = 1'b1;
    ch_tready[0] = 1'b1;
    start_ts = m_ts;
    for (int i = 0; i < 20; i++) begin
      ch_tdata[DW-1:0] = {$urandom, $urandom};
      step();
    end
    clear_links();
    step();
    chk("bp_count", fifo_count, 16);
    chk("bp_drop", drop_cnt[DRW-1:0], 3);
    chk("bp_ovf", overflow, 1'b1);
    rec_ready = 1'b1;
    n = 0;
    exp_ts = start_ts;
    for (int i = 0; i < 40; i++) begin
      if (rec_valid) begin
        chk("bp_ts", rec_ts, exp_ts);
        exp_ts = exp_ts + 1'b1;
        n++;
      end
      step();
    end
    chk("bp_records", n, 17);

    // ch1 every cycle with room in the FIFO: no drops.
    for (int i = 0; i < 30; i++) begin
      ch_tvalid[1] = 1'b1;
      ch_tready[1] = 1'b1;
      ch_tlast[1]  = 1'($urandom);
      ch_tdata[DW +: DW] = {$urandom, $urandom};
      step();
    end
    clear_links();
    repeat (5) step();
    chk("stream_drop", drop_cnt[DRW +: DRW], 0);
    chk("stream_empty", fifo_count, 0);

    // Three beats captured, then enable low while ch3 keeps streaming.
    rec_ready = 1'b0;
    ch_tvalid[3] = 1'b1;
    ch_tready[3] = 1'b1;
    repeat (3) step();
    enable = 1'b0;
    repeat (10) step();
    chk("en_count", fifo_count, 3);
    chk("en_drop", drop_cnt[3*DRW +: DRW], 0);
    clear_links();
    rec_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (rec_valid) n++;
      step();
    end
    chk("en_records", n, 3);
    enable = 1'b1;

    // Timestamp wrap 15 -> 0.
    while (m_ts != 4'd15) step();
    ch_tvalid[0] = 1'b1;
    ch_tready[0] = 1'b1;
    step();
    step();
    clear_links();
    chk("wrap_ts15", rec_ts, 15);
    step();
    chk("wrap_ts0", rec_ts, 0);
    repeat (3) step();

    // Reset mid-FIFO with five records queued.
    rec_ready = 1'b0;
    ch_tvalid[1] = 1'b1;
    ch_tready[1] = 1'b1;
    repeat (5) step();
    clear_links();
    repeat (3) step();
    chk("prerst_count", fifo_count, 5);
    #2;
    SoftReset_n = 1'b0;
    #1;
    chk("midrst_valid", rec_valid, 1'b0);
    chk("midrst_count", fifo_count, 0);
    chk("midrst_drop", drop_cnt, 0);
    chk("midrst_ovf", overflow, 1'b0);
    step();
    step();
    SoftReset_n = 1'b1;
    step();

    // Randomised traffic, alternating drainer pressure.
    for (int i = 0; i < 3000; i++) begin
      enable    = ($urandom_range(7) != 0);
      ch_tvalid = 4'($urandom);
      ch_tready = 4'($urandom);
      ch_tlast  = 4'($urandom);
      for (int c = 0; c < NCH; c++) ch_tdata[c*DW +: DW] = {$urandom, $urandom};
      rec_ready = ((i / 200) % 2 == 0) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
      step();
    end
    clear_links();
    enable    = 1'b1;
    rec_ready = 1'b1;
    repeat (40) step();
    chk("final_empty", fifo_count, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
